// File: rtl/keypad_scan_nd_display.sv
// Matrix keypad scanner with frame debounce and ghost rejection,
// feeding a shift-in hex digit buffer on a muxed 7-segment display.
module keypad_scan_nd_display #(
  parameter int CLK_FREQ        = 10_000_000,
  parameter int SCAN_RATE       = 1_000,
  parameter int REFRESH_RATE    = 1_000,
  parameter int ROWS            = 4,
  parameter int COLS            = 3,
  parameter int DIGITS          = 8,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                          sys_clk_in,
  input  logic                          reset,
  input  logic [COLS-1:0]               col_in,
  input  logic                          clear,
  output logic [ROWS-1:0]               row_out,
  output logic                          key_valid,
  output logic [3:0]                    key_code,
  output logic                          key_held,
  output logic [$clog2(DIGITS+1)-1:0]   digit_count,
  output logic [7:0]                    display_out,
  output logic [DIGITS-1:0]             seg_control
);

  localparam int SCAN_DIV  = CLK_FREQ / SCAN_RATE;
  localparam int DIGIT_DIV = CLK_FREQ / REFRESH_RATE;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_HELD,
    S_REL
  } state_t;

  logic [SW-1:0]   r_slot;
  logic [RW-1:0]   r_ridx;
  logic [ROWS-1:0] r_row;
  logic            w_slot_end;
  logic            w_last_row;
  logic            w_frame_end;
  logic [RW-1:0]   w_ridx_n;

  assign w_slot_end  = (r_slot == SW'(SCAN_DIV - 1));
  assign w_last_row  = (r_ridx == RW'(ROWS - 1));
  assign w_frame_end = w_slot_end & w_last_row;
  assign w_ridx_n    = w_last_row ? '0 : r_ridx + RW'(1);
  assign row_out     = r_row;

  // Slot counter and one-hot row rotation
  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      r_slot <= '0;
      r_ridx <= '0;
      r_row  <= ROWS'(1);
    end else if (w_slot_end) begin
      r_slot <= '0;
      r_ridx <= w_ridx_n;
      r_row  <= ROWS'(1) << w_ridx_n;
    end else begin
      r_slot <= r_slot + SW'(1);
    end
  end

  logic [2:0] w_ones;
  logic [1:0] w_col;
  logic [3:0] w_rcode;

  // Column popcount and index of the (last) active column
  always_comb begin
    w_ones = '0;
    w_col  = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_in[c]) begin
        w_ones = w_ones + 3'd1;
        w_col  = 2'(c);
      end
    end
  end

  assign w_rcode = 4'(int'(r_ridx) * COLS + int'(w_col));

  logic       r_seen;
  logic       r_multi;
  logic [3:0] r_fcode;
  logic       w_f_seen;
  logic       w_f_multi;
  logic [3:0] w_f_code;
  logic       w_none;
  logic       w_single;

  // A second hit anywhere in the frame, or two columns in one row, is MULTI
  assign w_f_multi = r_multi | (w_ones > 3'd1) |
                     (r_seen & (w_ones == 3'd1));
  assign w_f_seen  = r_seen | (w_ones != 3'd0);
  assign w_f_code  = r_seen ? r_fcode : w_rcode;
  assign w_none    = ~w_f_seen;
  assign w_single  = w_f_seen & ~w_f_multi;

  // Per-frame accumulation, restarted after the last row sample
  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      r_seen  <= 1'b0;
      r_multi <= 1'b0;
      r_fcode <= '0;
    end else if (w_slot_end) begin
      if (w_last_row) begin
        r_seen  <= 1'b0;
        r_multi <= 1'b0;
        r_fcode <= '0;
      end else begin
        r_seen  <= w_f_seen;
        r_multi <= w_f_multi;
        r_fcode <= w_f_code;
      end
    end
  end

  state_t        r_state;
  state_t        w_state_n;
  logic [FW-1:0] r_cnt;
  logic [FW-1:0] w_cnt_n;
  logic [3:0]    r_cand;
  logic [3:0]    w_cand_n;
  logic          w_accept;
  logic [3:0]    w_acode;

  // Debounce state register
  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_cand  <= w_cand_n;
    end
  end

  // Debounce next-state, stepped once per frame end
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_cand_n  = r_cand;
    w_accept  = 1'b0;
    w_acode   = r_cand;
    if (w_frame_end) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_n = w_f_code;
            w_cnt_n  = FW'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              w_state_n = S_HELD;
              w_accept  = 1'b1;
              w_acode   = w_f_code;
            end else begin
              w_state_n = S_PRESS;
            end
          end
        end
        S_PRESS: begin
          if (w_single && (w_f_code == r_cand)) begin
            w_cnt_n = r_cnt + FW'(1);
            if (w_cnt_n == FW'(DEBOUNCE_FRAMES)) begin
              w_state_n = S_HELD;
              w_accept  = 1'b1;
            end
          end else if (w_single) begin
            w_cand_n = w_f_code;
            w_cnt_n  = FW'(1);
          end else begin
            w_state_n = S_IDLE;
          end
        end
        S_HELD: begin
          if (w_none) begin
            w_cnt_n   = FW'(1);
            w_state_n = (DEBOUNCE_FRAMES == 1) ? S_IDLE : S_REL;
          end
        end
        S_REL: begin
          if (w_none) begin
            w_cnt_n = r_cnt + FW'(1);
            if (w_cnt_n == FW'(DEBOUNCE_FRAMES)) begin
              w_state_n = S_IDLE;
            end
          end else begin
            w_state_n = S_HELD;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  logic       r_valid;
  logic [3:0] r_code;

  // Accept strobe and held key code
  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_code  <= '0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) r_code <= w_acode;
    end
  end

  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign key_held  = (r_state == S_HELD) | (r_state == S_REL);

  logic [3:0]    r_buf [DIGITS];
  logic [NW-1:0] r_dcnt;

  // Digit buffer: push during the strobe cycle, clear has priority
  always_ff @(posedge sys_clk_in) begin
    if (reset || clear) begin
      for (int i = 0; i < DIGITS; i++) r_buf[i] <= '0;
      r_dcnt <= '0;
    end else if (r_valid) begin
      for (int i = DIGITS - 1; i > 0; i--) r_buf[i] <= r_buf[i-1];
      r_buf[0] <= r_code;
      if (r_dcnt != NW'(DIGITS)) r_dcnt <= r_dcnt + NW'(1);
    end
  end

  assign digit_count = r_dcnt;

  function automatic logic [7:0] f_font(input logic [3:0] v);
    logic [7:0] s;
    unique case (v)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      4'hF: s = 8'h71;
    endcase
    return s;
  endfunction

  logic [DW-1:0] r_ddiv;
  logic [IW-1:0] r_didx;
  logic [7:0]    r_disp;
  logic          w_tick;
  logic [IW-1:0] w_didx_n;

  assign w_tick   = (r_ddiv == DW'(DIGIT_DIV - 1));
  assign w_didx_n = !w_tick ? r_didx :
                    (r_didx == IW'(DIGITS - 1)) ? '0 : r_didx + IW'(1);

  // Digit mux; segments use the next index so they line up with the enable
  always_ff @(posedge sys_clk_in) begin
    if (reset) begin
      r_ddiv <= '0;
      r_didx <= '0;
      r_disp <= 8'h00;
    end else begin
      r_ddiv <= w_tick ? '0 : r_ddiv + DW'(1);
      r_didx <= w_didx_n;
      r_disp <= (NW'(w_didx_n) < r_dcnt) ? f_font(r_buf[w_didx_n]) : 8'h00;
    end
  end

  assign display_out = r_disp;
  assign seg_control = ~(DIGITS'(1) << r_didx);

endmodule

// File: tb/tb_keypad_scan_nd_display.sv
// Directed bench for keypad_scan_nd_display: scan timing, debounce,
// ghost rejection, digit buffer, display mux, clear and reset.
module tb_keypad_scan_nd_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic [2:0] col_in;
  logic [3:0] row_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [2:0] digit_count;
  logic [7:0] display_out;
  logic [3:0] seg_control;

  logic [2:0] keys [4];
  int nchk = 0;
  int npass = 0;
  int pcnt = 0;
  int base = 0;
  int n = 0;
  logic [7:0] exp_seg;

  keypad_scan_nd_display #(
    .CLK_FREQ(16),
    .SCAN_RATE(4),
    .REFRESH_RATE(8),
    .ROWS(4),
    .COLS(3),
    .DIGITS(4),
    .DEBOUNCE_FRAMES(2)
  ) dut (
    .sys_clk_in(clk),
    .reset(reset),
    .col_in(col_in),
    .clear(clear),
    .row_out(row_out),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held),
    .digit_count(digit_count),
    .display_out(display_out),
    .seg_control(seg_control)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row drive onto its column
  always_comb begin
    col_in = '0;
    for (int r = 0; r < 4; r++)
      if (row_out[r]) col_in = col_in | keys[r];
  end

  always @(posedge clk) if (key_valid) pcnt <= pcnt + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic no_keys();
    for (int r = 0; r < 4; r++) keys[r] = 3'b000;
  endtask

  task automatic sync_frame();
    int w;
    w = 0;
    while (row_out != 4'b1000 && w < 64) begin tick(1); w++; end
    while (row_out != 4'b0001 && w < 64) begin tick(1); w++; end
    check("sync", 32'(w < 64), 32'd1);
  endtask

  task automatic press(input int r, input logic [2:0] c);
    keys[r] = c;
    tick(48);
    keys[r] = 3'b000;
    tick(48);
  endtask

  initial begin
    no_keys();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    check("rst_row", 32'(row_out), 32'h1);
    check("rst_seg", 32'(seg_control), 32'hE);
    check("rst_disp", 32'(display_out), 32'h00);
    check("rst_cnt", 32'(digit_count), 32'd0);
    check("rst_kv", 32'(key_valid), 32'd0);
    check("rst_kc", 32'(key_code), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    tick(2);
    check("seg_step1", 32'(seg_control), 32'hD);
    tick(1);
    check("row_hold", 32'(row_out), 32'h1);
    tick(1);
    check("row_step", 32'(row_out), 32'h2);
    check("seg_step2", 32'(seg_control), 32'hB);

    sync_frame();
    base = pcnt;
    keys[1] = 3'b001;
    tick(32);
    check("acc_kv", 32'(key_valid), 32'd1);
    check("acc_kc", 32'(key_code), 32'd3);
    check("acc_held", 32'(key_held), 32'd1);
    tick(1);
    check("acc_kv_off", 32'(key_valid), 32'd0);
    check("acc_cnt", 32'(digit_count), 32'd1);
    tick(2);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      exp_seg = (seg_control == 4'b1110) ? 8'h4F : 8'h00;
      check("disp_one", 32'(display_out), 32'(exp_seg));
    end
    tick(5);
    keys[1] = 3'b000;
    tick(16);
    check("rel_held1", 32'(key_held), 32'd1);
    tick(16);
    check("rel_held0", 32'(key_held), 32'd0);
    check("acc_pulses", 32'(pcnt - base), 32'd1);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_cnt", 32'(digit_count), 32'd0);
    sync_frame();
    base = pcnt;
    for (int i = 0; i < 4; i++) begin
      keys[1] = 3'b001;
      tick(16);
      keys[1] = 3'b000;
      tick(16);
    end
    check("bounce_pulses", 32'(pcnt - base), 32'd0);
    check("bounce_cnt", 32'(digit_count), 32'd0);
    check("bounce_held", 32'(key_held), 32'd0);

    sync_frame();
    base = pcnt;
    keys[0] = 3'b011;
    tick(48);
    keys[0] = 3'b000;
    tick(16);
    check("chord_pulses", 32'(pcnt - base), 32'd0);
    keys[0] = 3'b001;
    keys[2] = 3'b001;
    tick(48);
    no_keys();
    tick(16);
    check("ghost_pulses", 32'(pcnt - base), 32'd0);
    check("ghost_held", 32'(key_held), 32'd0);
    keys[1] = 3'b001;
    tick(48);
    check("second_first", 32'(pcnt - base), 32'd1);
    keys[3] = 3'b010;
    tick(48);
    keys[1] = 3'b000;
    tick(48);
    check("second_held", 32'(key_held), 32'd1);
    keys[3] = 3'b000;
    tick(48);
    check("second_pulses", 32'(pcnt - base), 32'd1);
    check("second_kc", 32'(key_code), 32'd3);
    check("second_rel", 32'(key_held), 32'd0);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    sync_frame();
    base = pcnt;
    press(0, 3'b010);
    press(0, 3'b100);
    press(1, 3'b001);
    press(1, 3'b010);
    press(1, 3'b100);
    check("sat_pulses", 32'(pcnt - base), 32'd5);
    check("sat_cnt", 32'(digit_count), 32'd4);
    check("sat_kc", 32'(key_code), 32'd5);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      case (seg_control)
        4'b1110: exp_seg = 8'h6D;
        4'b1101: exp_seg = 8'h66;
        4'b1011: exp_seg = 8'h4F;
        4'b0111: exp_seg = 8'h5B;
        default: exp_seg = 8'hFF;
      endcase
      check("sat_disp", 32'(display_out), 32'(exp_seg));
    end

    sync_frame();
    keys[2] = 3'b010;
    n = 0;
    while (!key_valid && n < 64) begin tick(1); n++; end
    check("kv_wait", 32'(n < 64), 32'd1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clrpush_cnt", 32'(digit_count), 32'd0);
    check("clrpush_kv", 32'(key_valid), 32'd0);
    check("clrpush_kc", 32'(key_code), 32'd7);
    check("clrpush_held", 32'(key_held), 32'd1);
    tick(2);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("clr_blank", 32'(display_out), 32'h00);
    end
    keys[2] = 3'b000;
    tick(48);
    check("clr_rel", 32'(key_held), 32'd0);

    sync_frame();
    keys[2] = 3'b100;
    tick(16);
    check("mid_press", 32'(key_held), 32'd0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    base = pcnt;
    check("mid_kc", 32'(key_code), 32'd0);
    check("mid_row", 32'(row_out), 32'h1);
    check("mid_cnt", 32'(digit_count), 32'd0);
    tick(16);
    check("mid_f1_kv", 32'(key_valid), 32'd0);
    check("mid_f1_pulses", 32'(pcnt - base), 32'd0);
    tick(16);
    check("mid_f2_kv", 32'(key_valid), 32'd1);
    check("mid_f2_kc", 32'(key_code), 32'd8);
    tick(1);
    check("mid_pulses", 32'(pcnt - base), 32'd1);
    no_keys();
    tick(4);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
